// File: rtl/shared_functional_unit_arbiter_if.sv
// shared_functional_unit_arbiter_if: requester, FU and result-side signals of the shared FU arbiter
interface shared_functional_unit_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int OP_WIDTH = 4,
  parameter int WORD_WIDTH = 32,
  parameter int COUNTER_WIDTH = 32
);
  localparam int IW = $clog2(NUM_REQUESTERS);
  logic [NUM_REQUESTERS-1:0] requester_enable;
  logic [NUM_REQUESTERS-1:0] request_valid;
  logic [NUM_REQUESTERS-1:0] request_ready;
  logic [NUM_REQUESTERS*OP_WIDTH-1:0] request_op;
  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] request_operand_0;
  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] request_operand_1;
  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] request_operand_2;
  logic [OP_WIDTH-1:0] fu_op;
  logic [WORD_WIDTH-1:0] fu_operand_0;
  logic [WORD_WIDTH-1:0] fu_operand_1;
  logic [WORD_WIDTH-1:0] fu_operand_2;
  logic [WORD_WIDTH-1:0] fu_result;
  logic result_valid;
  logic result_ready;
  logic [WORD_WIDTH-1:0] result;
  logic [IW-1:0] result_requester_index;
  logic counter_clear;
  logic [COUNTER_WIDTH-1:0] busy_cycle_count;
  modport master (
    output requester_enable, request_valid, request_op, request_operand_0, request_operand_1,
           request_operand_2, fu_result, result_ready, counter_clear,
    input  request_ready, fu_op, fu_operand_0, fu_operand_1, fu_operand_2, result_valid, result,
           result_requester_index, busy_cycle_count
  );
  modport slave (
    input  requester_enable, request_valid, request_op, request_operand_0, request_operand_1,
           request_operand_2, fu_result, result_ready, counter_clear,
    output request_ready, fu_op, fu_operand_0, fu_operand_1, fu_operand_2, result_valid, result,
           result_requester_index, busy_cycle_count
  );
endinterface

// File: rtl/shared_functional_unit_arbiter.sv
// shared_functional_unit_arbiter: round-robin sharing of one single-cycle FU with a one-entry result register
module shared_functional_unit_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int OP_WIDTH = 4,
  parameter int WORD_WIDTH = 32,
  parameter logic [OP_WIDTH-1:0] OP_NOP = '0
) (
  input logic clock,
  input logic reset,
  shared_functional_unit_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQUESTERS);
  logic [NUM_REQUESTERS-1:0] eligible;
  logic [IW-1:0] grant_idx, cand, ptr_q, ptr_d, index_q, index_d;
  logic grant_valid, can_accept, fire;
  logic result_valid_q, result_valid_d;
  logic [WORD_WIDTH-1:0] result_q, result_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  assign eligible = bus.request_valid & bus.requester_enable;
  assign can_accept = !result_valid_q || bus.result_ready;
  // Scan from the highest offset down so the last hit is the one closest to the pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    cand = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQUESTERS);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end
  // Gating with reset keeps every output quiet while reset is held
  assign fire = !reset && grant_valid && can_accept;
  assign bus.request_ready = fire ? NUM_REQUESTERS'(1) << grant_idx : '0;
  assign bus.fu_op = fire ? bus.request_op[grant_idx*OP_WIDTH +: OP_WIDTH] : OP_NOP;
  assign bus.fu_operand_0 = fire ? bus.request_operand_0[grant_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign bus.fu_operand_1 = fire ? bus.request_operand_1[grant_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign bus.fu_operand_2 = fire ? bus.request_operand_2[grant_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  always_comb begin
    result_valid_d = fire ? 1'b1 : (bus.result_ready ? 1'b0 : result_valid_q);
    result_d = fire ? bus.fu_result : result_q;
    index_d = fire ? grant_idx : index_q;
    ptr_d = !fire ? ptr_q : (grant_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
    count_d = bus.counter_clear ? '0 : (fire && !(&count_q)) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid_q <= 1'b0;
      result_q <= '0;
      index_q <= '0;
      ptr_q <= '0;
      count_q <= '0;
    end else begin
      result_valid_q <= result_valid_d;
      result_q <= result_d;
      index_q <= index_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
    end
  end
  assign bus.result_valid = result_valid_q;
  assign bus.result = result_q;
  assign bus.result_requester_index = index_q;
  assign bus.busy_cycle_count = count_q;
endmodule

// File: tb/tb_shared_functional_unit_arbiter.sv
// tb_shared_functional_unit_arbiter: directed steps with a result scoreboard and a reference arbiter model
module tb_shared_functional_unit_arbiter;
  localparam int N = 4, OPW = 4, WW = 16, CW = 4, CMAX = 15;
  localparam logic [OPW-1:0] NOP = 4'd0, ADD = 4'd1, MAC = 4'd2, HALT = 4'd3;
  typedef struct {int idx; logic [WW-1:0] val;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int checks = 0, failures = 0, mptr = 0, mcount = 0;
  bit mv = 1'b0;
  always #5 clock = ~clock;
  shared_functional_unit_arbiter_if #(.NUM_REQUESTERS(N), .OP_WIDTH(OPW), .WORD_WIDTH(WW),
    .COUNTER_WIDTH(CW)) bus ();
  shared_functional_unit_arbiter #(.NUM_REQUESTERS(N), .COUNTER_WIDTH(CW), .OP_WIDTH(OPW),
    .WORD_WIDTH(WW), .OP_NOP(NOP)) dut (.clock(clock), .reset(reset), .bus(bus));
  function automatic logic [WW-1:0] gold(logic [OPW-1:0] op, logic [WW-1:0] a, b, c);
    return op == ADD ? a + b : op == MAC ? a + b * c : a ^ c;
  endfunction
  assign bus.fu_result = gold(bus.fu_op, bus.fu_operand_0, bus.fu_operand_1, bus.fu_operand_2);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int k, input logic [OPW-1:0] op, input logic [WW-1:0] a, b, c);
    bus.request_op[k*OPW +: OPW] = op;
    bus.request_operand_0[k*WW +: WW] = a;
    bus.request_operand_1[k*WW +: WW] = b;
    bus.request_operand_2[k*WW +: WW] = c;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.result_valid), 0);
    chk({tag, ".result"}, 32'(bus.result), 0);
    chk({tag, ".index"}, 32'(bus.result_requester_index), 0);
    chk({tag, ".ready"}, 32'(bus.request_ready), 0);
    chk({tag, ".fu_op"}, 32'(bus.fu_op), 32'(NOP));
    chk({tag, ".count"}, 32'(bus.busy_cycle_count), 0);
  endtask
  task automatic cycle(input string tag);
    bit f;
    int g;
    logic [N-1:0] elig;
    logic [OPW-1:0] op;
    #2;
    elig = bus.request_valid & bus.requester_enable;
    f = 1'b0;
    g = 0;
    if (!mv || bus.result_ready)
      for (int i = 0; i < N; i++) begin
        int k;
        k = (mptr + i) % N;
        if (!f && elig[k]) begin
          f = 1'b1;
          g = k;
        end
      end
    op = f ? bus.request_op[g*OPW +: OPW] : NOP;
    chk({tag, ".ready"}, 32'(bus.request_ready), f ? 32'(1) << g : 32'(0));
    chk({tag, ".fu_op"}, 32'(bus.fu_op), 32'(op));
    if (mv && q.size() > 0) begin
      chk({tag, ".result"}, 32'(bus.result), 32'(q[0].val));
      chk({tag, ".index"}, 32'(bus.result_requester_index), 32'(q[0].idx));
      if (bus.result_ready) void'(q.pop_front());
    end
    if (f) q.push_back('{g, gold(op, bus.request_operand_0[g*WW +: WW],
      bus.request_operand_1[g*WW +: WW], bus.request_operand_2[g*WW +: WW])});
    @(posedge clock);
    if (bus.counter_clear) mcount = 0;
    else if (f && mcount < CMAX) mcount++;
    if (f) begin
      mv = 1'b1;
      mptr = (g + 1) % N;
    end else if (bus.result_ready) mv = 1'b0;
    #1;
    chk({tag, ".rvalid"}, 32'(bus.result_valid), 32'(mv));
    chk({tag, ".count"}, 32'(bus.busy_cycle_count), 32'(mcount));
  endtask
  initial begin
    bus.requester_enable = '1;
    bus.request_valid = '0;
    bus.request_op = '0;
    bus.request_operand_0 = '0;
    bus.request_operand_1 = '0;
    bus.request_operand_2 = '0;
    bus.result_ready = 1'b0;
    bus.counter_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, ADD, WW'(k + 3), WW'(k + 4), 0);
    bus.request_valid = '1;
    bus.result_ready = 1'b1;
    repeat (5) cycle("add");
    bus.result_ready = 1'b0;
    repeat (3) cycle("stall");
    bus.result_ready = 1'b1;
    cycle("drain_refill");
    bus.requester_enable = 4'b1010;
    set_req(3, HALT, 16'h00f0, 0, 16'h000f);
    repeat (4) cycle("enable_mask");
    bus.requester_enable = '1;
    bus.request_valid = 4'b0100;
    cycle("ptr_setup");
    set_req(0, ADD, 1, 1, 0);
    set_req(2, MAC, 5, 2, 3);
    bus.request_valid = 4'b0101;
    cycle("wrap_grant0");
    bus.request_valid = 4'b0100;
    cycle("wrap_grant2");
    chk("mac.result", 32'(bus.result), 11);
    chk("mac.index", 32'(bus.result_requester_index), 2);
    bus.request_valid = '0;
    bus.counter_clear = 1'b1;
    cycle("clear_idle");
    bus.counter_clear = 1'b0;
    bus.request_valid = '1;
    repeat (20) cycle("saturate");
    chk("sat.count", 32'(bus.busy_cycle_count), CMAX);
    bus.counter_clear = 1'b1;
    cycle("clear_wins");
    chk("clear.count", 32'(bus.busy_cycle_count), 0);
    bus.counter_clear = 1'b0;
    cycle("pre_reset");
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    mv = 1'b0;
    mptr = 0;
    mcount = 0;
    q.delete();
    #1;
    reset = 1'b0;
    cycle("after_reset");
    bus.request_valid = '0;
    repeat (2) cycle("idle");
    chk("end.queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
